// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES carry slices, valid/ready on both sides.
// Define ADDER_SUBTRACT_EN to add the 'sub' port (a - b - carryin computed as a + ~b + !carryin).
module pipelined_ripple_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
`ifdef ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int S = WIDTH / STAGES;

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] advance;
  logic              sub_sel;

`ifdef ADDER_SUBTRACT_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // A valid stage moves on when out_ready is high or any stage above it is empty.
  always_comb begin : p_advance
    logic room;
    room    = out_ready;
    advance = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      advance[k] = valid[k] && room;
      room       = room || !valid[k];
    end
  end

  assign in_ready = !valid[0] || advance[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int BI = WIDTH - k * S;

    logic [WIDTH-1:0] word_in;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] word_q;
    logic [BI-1:0]    b_in;
    logic             carry_in;
    logic             sub_in;
    logic             up_valid;
    logic             valid_q;
    logic             carry_q;
    logic             load;
    logic [S-1:0]     a_slice;
    logic [S-1:0]     b_slice;
    logic [S:0]       slice;

    // word carries finished sum bits below this slice and untouched operand-A bits above it
    if (k == 0) begin : g_head
      assign word_in  = a;
      assign b_in     = b;
      assign carry_in = carryin ^ sub_sel;
      assign sub_in   = sub_sel;
      assign up_valid = in_valid;
    end else begin : g_body
      assign word_in  = g_stage[k-1].word_q;
      assign b_in     = g_stage[k-1].g_pass.b_q;
      assign carry_in = g_stage[k-1].carry_q;
      assign sub_in   = g_stage[k-1].g_pass.sub_q;
      assign up_valid = valid[k-1];
    end

    assign a_slice = word_in[k*S +: S];
    assign b_slice = b_in[S-1:0] ^ {S{sub_in}};
    assign slice   = {1'b0, a_slice} + {1'b0, b_slice} + {{S{1'b0}}, carry_in};
    assign load    = !valid_q || advance[k];

    always_comb begin
      word_next             = word_in;
      word_next[k*S +: S]   = slice[S-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= up_valid;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        word_q  <= '0;
        carry_q <= 1'b0;
      end else if (load && up_valid) begin
        word_q  <= word_next;
        carry_q <= slice[S];
      end
    end

    assign valid[k] = valid_q;

    if (k < STAGES - 1) begin : g_pass
      logic [BI-S-1:0] b_q;
      logic            sub_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          b_q   <= '0;
          sub_q <= 1'b0;
        end else if (load && up_valid) begin
          b_q   <= b_in[BI-1:S];
          sub_q <= sub_in;
        end
      end
    end else begin : g_last
      logic ovf_q;
      logic msb_carry;

      // carry into the MSB is recovered from the MSB sum bit and its operand bits
      assign msb_carry = slice[S-1] ^ a_slice[S-1] ^ b_slice[S-1];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ovf_q <= 1'b0;
        end else if (load && up_valid) begin
          ovf_q <= msb_carry ^ slice[S];
        end
      end

      assign sum       = word_q;
      assign carryout  = carry_q;
      assign overflow  = ovf_q;
      assign out_valid = valid_q;
    end
  end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder (WIDTH=32, STAGES=4) against an arithmetic reference model.
// Define ADDER_SUBTRACT_EN to also exercise the subtract mode.
module tb_pipelined_ripple_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam longint MAXS = (longint'(1) <<< (WIDTH - 1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (WIDTH - 1));

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             carryin   = 1'b0;
`ifdef ADDER_SUBTRACT_EN
  logic             sub       = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  result_t exp_q[$];

  pipelined_ripple_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .carryin(carryin),
`ifdef ADDER_SUBTRACT_EN
    .sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .carryout(carryout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned/signed arithmetic on wide integers
  function automatic result_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic cin, input logic do_sub);
    result_t          r;
    longint           sres;
    logic [WIDTH:0]   ux;
    if (do_sub) begin
      r.sum  = x - y - {{(WIDTH-1){1'b0}}, cin};
      r.cout = ({1'b0, x} >= ({1'b0, y} + {{WIDTH{1'b0}}, cin}));
      sres   = longint'($signed(x)) - longint'($signed(y)) - longint'(cin);
    end else begin
      ux     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
      r.sum  = ux[WIDTH-1:0];
      r.cout = ux[WIDTH];
      sres   = longint'($signed(x)) + longint'($signed(y)) + longint'(cin);
    end
    r.ovf = (sres > MAXS) || (sres < MINS);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c, input logic r);
    in_valid  = v;
    a         = x;
    b         = y;
    carryin   = c;
    out_ready = r;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, $urandom, $urandom, 1'b1, 1'(i));
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if ({sum, carryout, overflow} !== '0) begin
        fails++; $display("[TB] FAIL reset_outputs: got sum=%h cout=%b ovf=%b expected all 0", sum, carryout, overflow);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_release_out_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    drive(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL latency_accept: in_ready got %b expected 1", in_ready);
    end
    for (int cyc = 1; cyc <= STAGES; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== (cyc == STAGES)) begin
        fails++; $display("[TB] FAIL latency_out_valid cycle %0d: got %b expected %b", cyc, out_valid, cyc == STAGES);
      end
    end
    checks++;
    if ({sum, carryout, overflow} !== {32'h0000_0100, 1'b0, 1'b0}) begin
      fails++; $display("[TB] FAIL latency_result: got sum=%h cout=%b ovf=%b expected 00000100 0 0", sum, carryout, overflow);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL latency_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_carry_ripple();
    result_t want [2];
    int      got = 0;
    want[0] = '{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0};
    want[1] = '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1};
    @(negedge clk);
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 12 && got < 2; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if ({sum, carryout, overflow} !== want[got]) begin
          fails++; $display("[TB] FAIL ripple_result %0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                            got, sum, carryout, overflow, want[got].sum, want[got].cout, want[got].ovf);
        end
        got++;
      end
    end
    checks++;
    if (got != 2) begin
      fails++; $display("[TB] FAIL ripple_count: got %0d results expected 2", got);
    end
  endtask

  task automatic test_backpressure();
    int               sent = 0;
    int               got = 0;
    int               stall_at = -1;
    logic             held_v = 1'b0;
    logic [WIDTH-1:0] held_sum = '0;
    logic [WIDTH-1:0] x;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      @(negedge clk);
      x = WIDTH'(sent + 1);
      drive(sent < 10, x, x, 1'b0, !(cyc >= 3 && cyc <= 8));
      #1;
      if (in_ready === 1'b0 && stall_at < 0) stall_at = sent;
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== held_sum) begin
          fails++; $display("[TB] FAIL bp_hold: got valid=%b sum=%h expected valid=1 sum=%h", out_valid, sum, held_sum);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if ({sum, carryout, overflow} !== {WIDTH'(2 * (got + 1)), 1'b0, 1'b0}) begin
          fails++; $display("[TB] FAIL bp_order %0d: got sum=%0d cout=%b ovf=%b expected sum=%0d cout=0 ovf=0",
                            got, sum, carryout, overflow, 2 * (got + 1));
        end
        got++;
      end
      held_v   = (out_valid === 1'b1) && !out_ready;
      held_sum = sum;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (stall_at != STAGES) begin
      fails++; $display("[TB] FAIL bp_in_ready_drop: dropped after %0d accepts expected %0d", stall_at, STAGES);
    end
    checks++;
    if (got != 10) begin
      fails++; $display("[TB] FAIL bp_count: got %0d results expected 10", got);
    end
  endtask

  task automatic test_back_to_back();
    int               sent = 0;
    int               cyc = 0;
    logic             held_v = 1'b0;
    result_t          held = '0;
    result_t          e;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             s = 1'b0;
    exp_q.delete();
    while ((sent < 200 || exp_q.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) x = '1;
      if ($urandom_range(0, 7) == 0) y = {1'b0, {(WIDTH-1){1'b1}}};
      c = 1'($urandom_range(0, 1));
      drive((sent < 200) && ($urandom_range(0, 4) != 0), x, y, c, $urandom_range(0, 3) != 0);
`ifdef ADDER_SUBTRACT_EN
      s   = 1'($urandom_range(0, 1));
      sub = s;
`endif
      #1;
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || {sum, carryout, overflow} !== held) begin
          fails++; $display("[TB] FAIL b2b_hold: got valid=%b sum=%h cout=%b ovf=%b expected held sum=%h cout=%b ovf=%b",
                            out_valid, sum, carryout, overflow, held.sum, held.cout, held.ovf);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("[TB] FAIL b2b_unexpected: got sum=%h expected no result", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, carryout, overflow} !== e) begin
            fails++; $display("[TB] FAIL b2b_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                              sum, carryout, overflow, e.sum, e.cout, e.ovf);
          end
        end
      end
      held_v = (out_valid === 1'b1) && !out_ready;
      held   = {sum, carryout, overflow};
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(model(x, y, c, s));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
`ifdef ADDER_SUBTRACT_EN
    sub = 1'b0;
`endif
    checks++;
    if (cyc >= 3000) begin
      fails++; $display("[TB] FAIL b2b_timeout: %0d results outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int got = 0;
    int lat = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      drive(1'b1, WIDTH'(i), WIDTH'(i), 1'b0, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {sum, carryout, overflow} !== '0) begin
      fails++; $display("[TB] FAIL midreset_clear: got valid=%b sum=%h expected valid=0 sum=0", out_valid, sum);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        fails++; $display("[TB] FAIL midreset_stale: got out_valid=%b sum=%h expected out_valid=0", out_valid, sum);
      end
    end
    @(negedge clk);
    drive(1'b1, WIDTH'(5), WIDTH'(6), 1'b0, 1'b1);
    for (int cyc = 1; cyc <= 10 && got == 0; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid === 1'b1) begin
        got = 1;
        lat = cyc;
        checks++;
        if (sum !== WIDTH'(11)) begin
          fails++; $display("[TB] FAIL midreset_sum: got %0d expected 11", sum);
        end
      end
    end
    checks++;
    if (lat != STAGES) begin
      fails++; $display("[TB] FAIL midreset_latency: got %0d expected %0d", lat, STAGES);
    end
    @(negedge clk);
  endtask

`ifdef ADDER_SUBTRACT_EN
  task automatic test_subtract();
    result_t want [2];
    int      got = 0;
    want[0] = '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0};
    want[1] = '{sum: 32'h0000_0002, cout: 1'b1, ovf: 1'b0};
    @(negedge clk);
    sub = 1'b1;
    drive(1'b1, 32'd5, 32'd7, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'd7, 32'd5, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 12 && got < 2; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      sub      = 1'b0;
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if ({sum, carryout, overflow} !== want[got]) begin
          fails++; $display("[TB] FAIL sub_result %0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                            got, sum, carryout, overflow, want[got].sum, want[got].cout, want[got].ovf);
        end
        got++;
      end
    end
    checks++;
    if (got != 2) begin
      fails++; $display("[TB] FAIL sub_count: got %0d results expected 2", got);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_carry_ripple();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
`ifdef ADDER_SUBTRACT_EN
    test_subtract();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
